// File: rtl/laser_cover_eval.sv
// laser_cover_eval: captures the LASER target point stream, then on LASER DONE
// scans the stored points one per cycle and counts how many fall within
// RADIUS_SQ (squared distance, inclusive) of either returned circle centre.
module laser_cover_eval #(
    parameter int N_PTS     = 40,
    parameter int RADIUS_SQ = 16,
    parameter int CNT_W     = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PT_VALID,
    input  logic [3:0]       X,
    input  logic [3:0]       Y,
    input  logic             DONE_IN,
    input  logic [3:0]       C1X,
    input  logic [3:0]       C1Y,
    input  logic [3:0]       C2X,
    input  logic [3:0]       C2Y,
    input  logic             CLR,
    output logic [CNT_W-1:0] PT_CNT,
    output logic             BUSY,
    output logic             EVAL_DONE,
    output logic [CNT_W-1:0] COVER,
    output logic             OVF
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [CNT_W-1:0] NPTS_C = CNT_W'(N_PTS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [8:0]       RAD_C  = 9'(RADIUS_SQ);

    // Squared Euclidean distance on 4-bit coordinates; max 2*15^2 = 450 fits 9 bits.
    function automatic logic [8:0] dist_sq(input logic [3:0] ax, input logic [3:0] ay,
                                           input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        sx = 8'(dx) * 8'(dx);
        sy = 8'(dy) * 8'(dy);
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic [CNT_W-1:0] cover_q, cover_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             eval_q, eval_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       c1x_q, c1y_q, c2x_q, c2y_q;
    logic [3:0]       c1x_d, c1y_d, c2x_d, c2y_d;

    logic [7:0]       buf_q [N_PTS];
    logic             wr_en;
    logic [7:0]       pt_rd;
    logic [8:0]       d1, d2;
    logic             hit;

    // Combinational buffer read at the scan index, plus coverage test.
    always_comb begin
        pt_rd = buf_q[idx_q];
        d1    = dist_sq(c1x_q, c1y_q, pt_rd[7:4], pt_rd[3:0]);
        d2    = dist_sq(c2x_q, c2y_q, pt_rd[7:4], pt_rd[3:0]);
        hit   = (d1 <= RAD_C) || (d2 <= RAD_C);
    end

    // Next-state logic: CLR beats everything; point write precedes DONE so a
    // simultaneous point is included in the scan.
    always_comb begin
        state_d  = state_q;
        pt_cnt_d = pt_cnt_q;
        cover_d  = cover_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        eval_d   = eval_q;
        ovf_d    = ovf_q;
        c1x_d    = c1x_q;
        c1y_d    = c1y_q;
        c2x_d    = c2x_q;
        c2y_d    = c2y_q;
        wr_en    = 1'b0;
        if (CLR) begin
            state_d  = S_LOAD;
            pt_cnt_d = '0;
            cover_d  = '0;
            idx_d    = '0;
            busy_d   = 1'b0;
            eval_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (PT_VALID) begin
                        if (pt_cnt_q < NPTS_C) begin
                            wr_en    = 1'b1;
                            pt_cnt_d = pt_cnt_q + ONE_C;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (DONE_IN) begin
                        c1x_d   = C1X;
                        c1y_d   = C1Y;
                        c2x_d   = C2X;
                        c2y_d   = C2Y;
                        cover_d = '0;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Empty buffer: nothing to evaluate, finish after one cycle.
                    if ((idx_q < pt_cnt_q) && hit)
                        cover_d = cover_q + ONE_C;
                    idx_d = idx_q + ONE_C;
                    if ((pt_cnt_q == '0) || (idx_q == pt_cnt_q - ONE_C)) begin
                        busy_d  = 1'b0;
                        eval_d  = 1'b1;
                        state_d = S_REPORT;
                    end
                end
                S_REPORT: ;
                default: state_d = S_LOAD;
            endcase
        end
    end

    // Control and result registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_LOAD;
            pt_cnt_q <= '0;
            cover_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            eval_q   <= 1'b0;
            ovf_q    <= 1'b0;
            c1x_q    <= '0;
            c1y_q    <= '0;
            c2x_q    <= '0;
            c2y_q    <= '0;
        end else begin
            state_q  <= state_d;
            pt_cnt_q <= pt_cnt_d;
            cover_q  <= cover_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            eval_q   <= eval_d;
            ovf_q    <= ovf_d;
            c1x_q    <= c1x_d;
            c1y_q    <= c1y_d;
            c2x_q    <= c2x_d;
            c2y_q    <= c2y_d;
        end
    end

    // Point buffer: contents are don't-care after reset, so no reset needed.
    always_ff @(posedge CLK) begin
        if (wr_en)
            buf_q[pt_cnt_q] <= {X, Y};
    end

    assign PT_CNT    = pt_cnt_q;
    assign BUSY      = busy_q;
    assign EVAL_DONE = eval_q;
    assign COVER     = cover_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_laser_cover_eval.sv
// Directed bench for laser_cover_eval: hand-computed coverage counts, scan
// latency, overflow, CLR priority, ignored events and mid-scan reset.
module tb_laser_cover_eval;

    logic       CLK = 1'b0;
    logic       RST, PT_VALID, DONE_IN, CLR;
    logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
    logic [5:0] PT_CNT, COVER;
    logic       BUSY, EVAL_DONE, OVF;

    int n_chk  = 0;
    int n_pass = 0;
    int lat, bsy, exp_cov;

    laser_cover_eval #(.N_PTS(40), .RADIUS_SQ(16), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y),
        .DONE_IN(DONE_IN), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .CLR(CLR), .PT_CNT(PT_CNT), .BUSY(BUSY), .EVAL_DONE(EVAL_DONE),
        .COVER(COVER), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pt(input int px, input int py);
        X = 4'(px); Y = 4'(py); PT_VALID = 1'b1;
        step();
        PT_VALID = 1'b0;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    // Pulse DONE_IN for one edge, then wait (bounded) for EVAL_DONE.
    task automatic run_scan(input int ax, input int ay, input int bx, input int by,
                            output int l, output int b);
        C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by); DONE_IN = 1'b1;
        step();
        DONE_IN = 1'b0;
        b = BUSY ? 1 : 0;
        l = 0;
        while (!EVAL_DONE && l < 200) begin
            step();
            l++;
            if (BUSY) b++;
        end
    endtask

    function automatic int covered(input int px, input int py, input int ax, input int ay,
                                   input int bx, input int by);
        int da, db;
        da = (px - ax) * (px - ax) + (py - ay) * (py - ay);
        db = (px - bx) * (px - bx) + (py - by) * (py - by);
        return (da <= 16 || db <= 16) ? 1 : 0;
    endfunction

    initial begin
        RST = 1'b1; PT_VALID = 1'b0; DONE_IN = 1'b0; CLR = 1'b0;
        X = '0; Y = '0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
        #2;
        chk("rst_ptcnt", PT_CNT, 0);
        chk("rst_cover", COVER, 0);
        chk("rst_flags", {BUSY, EVAL_DONE, OVF}, 0);
        step(); step();
        RST = 1'b0;
        step();

        // Full load, best case
        for (int i = 0; i < 40; i++) load_pt(0, 0);
        chk("full_ptcnt", PT_CNT, 40);
        chk("full_ovf", OVF, 0);
        run_scan(0, 0, 15, 15, lat, bsy);
        chk("full_latency", lat, 40);
        chk("full_busy_cycles", bsy, 40);
        chk("full_cover", COVER, 40);
        chk("full_busy_end", BUSY, 0);
        // REPORT holds: DONE_IN and PT_VALID ignored
        C1X = 4'd15; DONE_IN = 1'b1; PT_VALID = 1'b1;
        step(); step();
        DONE_IN = 1'b0; PT_VALID = 1'b0;
        chk("report_cover_hold", COVER, 40);
        chk("report_ptcnt_hold", PT_CNT, 40);
        chk("report_eval_hold", {EVAL_DONE, BUSY, OVF}, 3'b100);
        do_clr();
        chk("clr_state", {PT_CNT, COVER, EVAL_DONE, BUSY}, 0);

        // Radius boundaries: d = 16,16,17,18,13
        load_pt(4, 0); load_pt(0, 4); load_pt(4, 1); load_pt(3, 3); load_pt(2, 3);
        run_scan(0, 0, 15, 15, lat, bsy);
        chk("radius_latency", lat, 5);
        chk("radius_cover", COVER, 3);
        do_clr();

        // Double coverage counted once, far point not covered
        load_pt(5, 5); load_pt(15, 0);
        run_scan(3, 5, 7, 5, lat, bsy);
        chk("double_cover", COVER, 1);
        chk("double_ptcnt", PT_CNT, 2);
        do_clr();

        // Empty buffer: straight through SCAN to REPORT
        run_scan(0, 0, 15, 15, lat, bsy);
        chk("empty_latency", lat, 1);
        chk("empty_busy_cycles", bsy, 1);
        chk("empty_cover", COVER, 0);
        do_clr();

        // Overflow, then CLR beats simultaneous PT_VALID and DONE_IN
        for (int i = 0; i < 42; i++) load_pt(1, 1);
        chk("ovf_ptcnt", PT_CNT, 40);
        chk("ovf_flag", OVF, 1);
        CLR = 1'b1; PT_VALID = 1'b1; DONE_IN = 1'b1;
        step();
        CLR = 1'b0; PT_VALID = 1'b0; DONE_IN = 1'b0;
        chk("ovf_clr_ptcnt", PT_CNT, 0);
        chk("ovf_clr_flags", {OVF, BUSY, EVAL_DONE}, 0);

        // 10th point on the DONE_IN edge; points (i,0) -> i<=4 covered by C1=(0,0)
        for (int i = 0; i < 9; i++) load_pt(i, 0);
        X = 4'd9; Y = 4'd0; PT_VALID = 1'b1;
        C1X = 4'd0; C1Y = 4'd0; C2X = 4'd15; C2Y = 4'd15; DONE_IN = 1'b1;
        step();
        PT_VALID = 1'b0; DONE_IN = 1'b0;
        lat = 0;
        while (!EVAL_DONE && lat < 200) begin
            if (lat == 2) begin
                C1X = 4'd9; X = 4'd0; Y = 4'd0; DONE_IN = 1'b1; PT_VALID = 1'b1;
            end
            if (lat == 4) begin
                DONE_IN = 1'b0; PT_VALID = 1'b0;
            end
            step();
            lat++;
        end
        DONE_IN = 1'b0; PT_VALID = 1'b0;
        chk("simul_latency", lat, 10);
        chk("simul_cover", COVER, 5);
        chk("simul_ptcnt", PT_CNT, 10);
        chk("simul_ovf", OVF, 0);
        do_clr();

        // Reset 5 cycles into a 40-point scan
        for (int i = 0; i < 40; i++) load_pt(i % 16, i / 16);
        C1X = 4'd2; C1Y = 4'd1; C2X = 4'd12; C2Y = 4'd2; DONE_IN = 1'b1;
        step();
        DONE_IN = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midscan_busy", BUSY, 1);
        RST = 1'b1;
        #1;
        chk("midrst_ptcnt", PT_CNT, 0);
        chk("midrst_cover", COVER, 0);
        chk("midrst_flags", {BUSY, EVAL_DONE, OVF}, 0);
        step();
        RST = 1'b0;
        step();
        exp_cov = 0;
        for (int i = 0; i < 40; i++) begin
            load_pt(i % 16, i / 16);
            exp_cov += covered(i % 16, i / 16, 2, 1, 12, 2);
        end
        run_scan(2, 1, 12, 2, lat, bsy);
        chk("rescan_latency", lat, 40);
        chk("rescan_cover", COVER, exp_cov);
        chk("rescan_ptcnt", PT_CNT, 40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
